// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// A write is an {addr, data} pair; writes come from source A (ALU) or source B (load).
package rf_pkg;

   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 3;
   localparam int unsigned NREG = 2 ** AW;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } rf_wr_t;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } rf_src_e;

   function automatic rf_src_e rf_src_other(input rf_src_e src);
      return (src == SRC_A) ? SRC_B : SRC_A;
   endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding register for a pending register-file write.
// A load on the same edge as a drain takes priority, so the slot refills without a bubble.
module rf_wr_slot
   import rf_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   load_i,
   input  logic   drain_i,
   input  rf_wr_t entry_i,
   output logic   full_o,
   output rf_wr_t entry_o
);

   logic   full_q, full_d;
   rf_wr_t entry_q, entry_d;

   always_comb begin
      full_d  = load_i | (full_q & ~drain_i);
      entry_d = load_i ? entry_i : entry_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q  <= 1'b0;
         entry_q <= '0;
      end else begin
         full_q  <= full_d;
         entry_q <= entry_d;
      end
   end

   assign full_o  = full_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback sources,
// granting oldest-first with round-robin tie break, and flags read-after-write hazards.
module rf_write_arbiter
   import rf_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          b_ready,
   output logic          rf_wr_en,
   output logic [AW-1:0] rf_wr_addr,
   output logic [DW-1:0] rf_dat_in,
   input  logic [AW-1:0] rd_addrA,
   input  logic [AW-1:0] rd_addrB,
   output logic          hazA,
   output logic          hazB,
   output logic          idle
);

   logic    a_full, b_full;
   rf_wr_t  a_entry, b_entry, a_in, b_in;
   logic    grant_a, grant_b, load_a, load_b;
   rf_src_e sel;

   // older_q names the slot that filled first; only meaningful while both are full
   // and they were not loaded on the same edge (tie_q).
   rf_src_e older_q, older_d;
   rf_src_e rr_q, rr_d;
   logic    tie_q, tie_d;
   logic    wr_en_q, wr_en_d;
   rf_wr_t  wr_q, wr_d;

   assign a_in = '{addr: a_addr, data: a_data};
   assign b_in = '{addr: b_addr, data: b_data};

   always_comb begin
      sel     = tie_q ? rr_q : older_q;
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (a_full && b_full) begin
         grant_a = (sel == SRC_A);
         grant_b = (sel == SRC_B);
      end else begin
         grant_a = a_full;
         grant_b = b_full;
      end
   end

   assign a_ready = ~a_full | grant_a;
   assign b_ready = ~b_full | grant_b;
   assign load_a  = a_valid & a_ready;
   assign load_b  = b_valid & b_ready;

   always_comb begin
      older_d = older_q;
      if (load_a && !load_b) begin
         older_d = SRC_B;
      end else if (load_b && !load_a) begin
         older_d = SRC_A;
      end
      tie_d   = load_a & load_b;
      rr_d    = (a_full && b_full && tie_q) ? rf_src_other(rr_q) : rr_q;
      wr_en_d = grant_a | grant_b;
      wr_d    = grant_a ? a_entry : (grant_b ? b_entry : wr_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         older_q <= SRC_A;
         rr_q    <= SRC_A;
         tie_q   <= 1'b0;
         wr_en_q <= 1'b0;
         wr_q    <= '0;
      end else begin
         older_q <= older_d;
         rr_q    <= rr_d;
         tie_q   <= tie_d;
         wr_en_q <= wr_en_d;
         wr_q    <= wr_d;
      end
   end

   rf_wr_slot u_slot_a (
      .clk_i   (clk),
      .rst_ni  (reset),
      .load_i  (load_a),
      .drain_i (grant_a),
      .entry_i (a_in),
      .full_o  (a_full),
      .entry_o (a_entry)
   );

   rf_wr_slot u_slot_b (
      .clk_i   (clk),
      .rst_ni  (reset),
      .load_i  (load_b),
      .drain_i (grant_b),
      .entry_i (b_in),
      .full_o  (b_full),
      .entry_o (b_entry)
   );

   assign rf_wr_en   = wr_en_q;
   assign rf_wr_addr = wr_q.addr;
   assign rf_dat_in  = wr_q.data;

   assign hazA = (a_full && a_entry.addr == rd_addrA) || (b_full && b_entry.addr == rd_addrA) ||
                 (wr_en_q && wr_q.addr == rd_addrA);
   assign hazB = (a_full && a_entry.addr == rd_addrB) || (b_full && b_entry.addr == rd_addrB) ||
                 (wr_en_q && wr_q.addr == rd_addrB);
   assign idle = ~a_full & ~b_full & ~wr_en_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a timestamp-ordered slot model.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0, rd_addrA = '0, rd_addrB = '0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_ready, b_ready, rf_wr_en, hazA, hazB, idle;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_dat_in;

   always #5 clk = ~clk;

   rf_write_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .a_valid    (a_valid),
      .a_addr     (a_addr),
      .a_data     (a_data),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .b_ready    (b_ready),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_dat_in  (rf_dat_in),
      .rd_addrA   (rd_addrA),
      .rd_addrB   (rd_addrB),
      .hazA       (hazA),
      .hazB       (hazB),
      .idle       (idle)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: each slot remembers the cycle it was accepted; older stamp wins,
   // equal stamps alternate starting with A.
   bit            m_a_full, m_b_full, m_wr_en;
   logic [AW-1:0] m_a_addr, m_b_addr, m_wr_addr;
   logic [DW-1:0] m_a_data, m_b_data, m_wr_data;
   int            m_a_ts, m_b_ts, m_rr, cyc;
   bit            acc_a, acc_b;

   logic [DW-1:0]    dut_rf [NREG];
   logic [AW+DW-1:0] wr_log[$];
   int               run_len, max_run;

   task automatic model_clear();
      m_a_full = 0; m_b_full = 0; m_wr_en = 0; m_rr = 0;
      m_wr_addr = '0; m_wr_data = '0;
   endtask

   // Called right after inputs change on a falling edge; returns on the next falling edge.
   task automatic tick();
      int g;
      bit tie, exp_ra, exp_rb, exp_ha, exp_hb;
      #1;
      g = 0;
      tie = 0;
      if (m_a_full && m_b_full) begin
         if (m_a_ts < m_b_ts) g = 1;
         else if (m_b_ts < m_a_ts) g = 2;
         else begin
            tie = 1;
            g = (m_rr == 0) ? 1 : 2;
         end
      end else if (m_a_full) g = 1;
      else if (m_b_full) g = 2;
      exp_ra = !m_a_full || g == 1;
      exp_rb = !m_b_full || g == 2;
      exp_ha = (m_a_full && m_a_addr == rd_addrA) || (m_b_full && m_b_addr == rd_addrA) ||
               (m_wr_en && m_wr_addr == rd_addrA);
      exp_hb = (m_a_full && m_a_addr == rd_addrB) || (m_b_full && m_b_addr == rd_addrB) ||
               (m_wr_en && m_wr_addr == rd_addrB);
      check_eq("a_ready", 32'(a_ready), 32'(exp_ra));
      check_eq("b_ready", 32'(b_ready), 32'(exp_rb));
      check_eq("rf_wr_en", 32'(rf_wr_en), 32'(m_wr_en));
      check_eq("rf_wr_addr", 32'(rf_wr_addr), 32'(m_wr_addr));
      check_eq("rf_dat_in", 32'(rf_dat_in), 32'(m_wr_data));
      check_eq("hazA", 32'(hazA), 32'(exp_ha));
      check_eq("hazB", 32'(hazB), 32'(exp_hb));
      check_eq("idle", 32'(idle), 32'(!m_a_full && !m_b_full && !m_wr_en));
      if (rf_wr_en) begin
         dut_rf[rf_wr_addr] = rf_dat_in;
         wr_log.push_back({rf_wr_addr, rf_dat_in});
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
      if (g == 1) begin
         m_wr_en = 1; m_wr_addr = m_a_addr; m_wr_data = m_a_data; m_a_full = 0;
      end else if (g == 2) begin
         m_wr_en = 1; m_wr_addr = m_b_addr; m_wr_data = m_b_data; m_b_full = 0;
      end else begin
         m_wr_en = 0;
      end
      acc_a = a_valid && exp_ra;
      acc_b = b_valid && exp_rb;
      if (acc_a) begin
         m_a_full = 1; m_a_addr = a_addr; m_a_data = a_data; m_a_ts = cyc;
      end
      if (acc_b) begin
         m_b_full = 1; m_b_addr = b_addr; m_b_data = b_data; m_b_ts = cyc;
      end
      if (tie) m_rr ^= 1;
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      rd_addrA = ra; rd_addrB = rb;
      tick();
   endtask

   task automatic idle_cycles(input int n, input logic [AW-1:0] ra);
      for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, ra, '0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      #2 reset = 1'b0;
      a_valid = 0;
      b_valid = 0;
      #1;
      model_clear();
      check_eq("rst_wr_en", 32'(rf_wr_en), 32'd0);
      check_eq("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
      check_eq("rst_dat_in", 32'(rf_dat_in), 32'd0);
      check_eq("rst_a_ready", 32'(a_ready), 32'd1);
      check_eq("rst_b_ready", 32'(b_ready), 32'd1);
      check_eq("rst_idle", 32'(idle), 32'd1);
      check_eq("rst_hazA", 32'(hazA), 32'd0);
      check_eq("rst_hazB", 32'(hazB), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      run_len = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int a_idx, b_idx, n_a, n_b;
      int cnt_a [20];
      int cnt_b [20];
      bit pa, pb;
      logic [AW-1:0] pa_addr, pb_addr;
      logic [DW-1:0] pa_data, pb_data;

      for (int i = 0; i < int'(NREG); i++) dut_rf[i] = '0;
      cyc = 0;
      run_len = 0;
      max_run = 0;
      @(negedge clk);
      do_reset();

      // Single A write with a hazard watch on its address.
      wr_log.delete();
      drive(1, 3'd3, 8'h5A, 0, '0, '0, 3'd3, 3'd1);
      idle_cycles(3, 3'd3);
      check_eq("single_count", 32'(wr_log.size()), 32'd1);
      check_eq("single_write", 32'(wr_log[0]), 32'({3'd3, 8'h5A}));

      // Same-edge ties alternate, starting with A.
      wr_log.delete();
      drive(1, 3'd2, 8'h11, 1, 3'd5, 8'h22, 3'd2, 3'd5);
      idle_cycles(3, '0);
      drive(1, 3'd2, 8'h11, 1, 3'd5, 8'h22, 3'd2, 3'd5);
      idle_cycles(3, '0);
      check_eq("tie_count", 32'(wr_log.size()), 32'd4);
      check_eq("tie1_first", 32'(wr_log[0]), 32'({3'd2, 8'h11}));
      check_eq("tie1_second", 32'(wr_log[1]), 32'({3'd5, 8'h22}));
      check_eq("tie2_first", 32'(wr_log[2]), 32'({3'd5, 8'h22}));
      check_eq("tie2_second", 32'(wr_log[3]), 32'({3'd2, 8'h11}));

      // Age ordering to the same register: the later write must persist.
      wr_log.delete();
      drive(0, '0, '0, 1, 3'd4, 8'hAA, 3'd4, 3'd4);
      drive(1, 3'd4, 8'hBB, 0, '0, '0, 3'd4, 3'd4);
      idle_cycles(3, 3'd4);
      check_eq("age_first", 32'(wr_log[0]), 32'({3'd4, 8'hAA}));
      check_eq("age_second", 32'(wr_log[1]), 32'({3'd4, 8'hBB}));
      check_eq("age_reg4", 32'(dut_rf[4]), 32'h0BB);

      // Sustained A stream.
      wr_log.delete();
      max_run = 0;
      for (int i = 0; i < 16; i++) drive(1, AW'(i), DW'(8'h40 + i), 0, '0, '0, '0, '0);
      idle_cycles(3, '0);
      check_eq("sustain_count", 32'(wr_log.size()), 32'd16);
      check_eq("sustain_run", 32'(max_run), 32'd16);
      for (int i = 0; i < 16; i++)
         check_eq("sustain_data", 32'(wr_log[i][DW-1:0]), 32'(8'h40 + i));

      // Contention: both sources hold valid until 20 writes each are accepted.
      wr_log.delete();
      a_idx = 0;
      b_idx = 0;
      for (int c = 0; c < 200 && (a_idx < 20 || b_idx < 20); c++) begin
         drive(a_idx < 20, AW'(a_idx), DW'(a_idx), b_idx < 20, AW'(b_idx + 3),
               DW'(8'h80 + b_idx), AW'(c), AW'(c + 1));
         if (acc_a) a_idx++;
         if (acc_b) b_idx++;
      end
      idle_cycles(4, '0);
      check_eq("cont_a_accepted", 32'(a_idx), 32'd20);
      check_eq("cont_b_accepted", 32'(b_idx), 32'd20);
      for (int i = 0; i < 20; i++) begin
         cnt_a[i] = 0;
         cnt_b[i] = 0;
      end
      n_a = 0;
      n_b = 0;
      foreach (wr_log[i]) begin
         if (wr_log[i][7]) begin
            n_b++;
            if (int'(wr_log[i][6:0]) < 20) cnt_b[int'(wr_log[i][6:0])]++;
         end else begin
            n_a++;
            if (int'(wr_log[i][6:0]) < 20) cnt_a[int'(wr_log[i][6:0])]++;
         end
      end
      check_eq("cont_a_writes", 32'(n_a), 32'd20);
      check_eq("cont_b_writes", 32'(n_b), 32'd20);
      for (int i = 0; i < 20; i++) begin
         check_eq("cont_a_once", 32'(cnt_a[i]), 32'd1);
         check_eq("cont_b_once", 32'(cnt_b[i]), 32'd1);
      end
      check_eq("cont_idle", 32'(idle), 32'd1);

      // Random traffic with requester hold semantics and occasional mid-burst resets.
      pa = 0;
      pb = 0;
      pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
      for (int c = 0; c < 600; c++) begin
         if (c % 150 == 149) begin
            do_reset();
            pa = 0;
            pb = 0;
         end
         if (!pa && $urandom_range(0, 9) < 7) begin
            pa = 1;
            pa_addr = AW'($urandom);
            pa_data = DW'($urandom);
         end
         if (!pb && $urandom_range(0, 9) < 6) begin
            pb = 1;
            pb_addr = AW'($urandom);
            pb_data = DW'($urandom);
         end
         drive(pa, pa_addr, pa_data, pb, pb_addr, pb_data, AW'($urandom), AW'($urandom));
         if (acc_a) pa = 0;
         if (acc_b) pb = 0;
      end
      idle_cycles(4, '0);
      check_eq("final_idle", 32'(idle), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
